// File: rtl/bsg_chip_link_bringup_seq.sv
// bsg_chip_link_bringup_seq
// Sequences the reset pins of every selected bsg_link from a single start pulse.
// Order: assert all -> token pulse high -> token low -> release upstream io ->
// release downstream io -> release core. Each stage holds for W cycles.
// Every output pin is driven straight from its own flop.
module bsg_chip_link_bringup_seq #(
   parameter int num_links_p  = 18,
   parameter int wait_width_p = 16
) (
   input  logic                    clk_i,
   input  logic                    reset_i,
   input  logic                    start_i,
   input  logic                    abort_i,
   input  logic [num_links_p-1:0]  link_mask_i,
   input  logic [wait_width_p-1:0] wait_cycles_i,
   output logic [num_links_p-1:0]  token_reset_o,
   output logic [num_links_p-1:0]  io_up_reset_o,
   output logic [num_links_p-1:0]  io_dn_reset_o,
   output logic [num_links_p-1:0]  core_reset_o,
   output logic                    busy_o,
   output logic                    done_o
);

   localparam logic [2:0] st_idle_lp   = 3'd0;
   localparam logic [2:0] st_assert_lp = 3'd1;
   localparam logic [2:0] st_tok_hi_lp = 3'd2;
   localparam logic [2:0] st_tok_lo_lp = 3'd3;
   localparam logic [2:0] st_io_up_lp  = 3'd4;
   localparam logic [2:0] st_io_dn_lp  = 3'd5;
   localparam logic [2:0] st_done_lp   = 3'd6;

   localparam logic [wait_width_p-1:0] cnt_zero_lp = {wait_width_p{1'b0}};
   localparam logic [wait_width_p-1:0] cnt_one_lp  = {{(wait_width_p-1){1'b0}}, 1'b1};
   localparam logic [num_links_p-1:0]  links_one_lp  = {num_links_p{1'b1}};
   localparam logic [num_links_p-1:0]  links_zero_lp = {num_links_p{1'b0}};

   logic [2:0]              state_q, state_d;
   logic [wait_width_p-1:0] cnt_q, cnt_d;
   logic [wait_width_p-1:0] w_q, w_d;
   logic [num_links_p-1:0]  mask_q, mask_d;
   logic [num_links_p-1:0]  tok_q, tok_d;
   logic [num_links_p-1:0]  up_q, up_d;
   logic [num_links_p-1:0]  dn_q, dn_d;
   logic [num_links_p-1:0]  core_q, core_d;
   logic                    busy_q, busy_d;
   logic                    done_q, done_d;
   logic [wait_width_p-1:0] w_in_s;
   logic [num_links_p-1:0]  abort_sel_s;
   logic                    idle_like_s;

   // Sequencer state, stage hold counter and the operands latched at start.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      w_d         = w_q;
      mask_d      = mask_q;
      w_in_s      = (wait_cycles_i == cnt_zero_lp) ? cnt_one_lp : wait_cycles_i;
      idle_like_s = (state_q == st_idle_lp) || (state_q == st_done_lp);
      if (abort_i) begin
         state_d = st_idle_lp;
         cnt_d   = cnt_zero_lp;
      end else if (idle_like_s) begin
         if (start_i) begin
            mask_d  = link_mask_i;
            w_d     = w_in_s;
            cnt_d   = w_in_s - cnt_one_lp;
            state_d = st_assert_lp;
         end else begin
            state_d = state_q;
         end
      end else if (cnt_q == cnt_zero_lp) begin
         // Stage expired: move on and reload the hold count for the next stage.
         cnt_d = w_q - cnt_one_lp;
         case (state_q)
            st_assert_lp: state_d = st_tok_hi_lp;
            st_tok_hi_lp: state_d = st_tok_lo_lp;
            st_tok_lo_lp: state_d = st_io_up_lp;
            st_io_up_lp:  state_d = st_io_dn_lp;
            st_io_dn_lp:  state_d = st_done_lp;
            default:      state_d = st_idle_lp;
         endcase
      end else begin
         cnt_d = cnt_q - cnt_one_lp;
      end
   end

   // Next pin levels: only links in the active mask move; others hold their bits.
   always_comb begin
      tok_d       = tok_q;
      up_d        = up_q;
      dn_d        = dn_q;
      core_d      = core_q;
      busy_d      = busy_q;
      done_d      = done_q;
      abort_sel_s = busy_q ? mask_q : link_mask_i;
      if (abort_i) begin
         tok_d  = tok_q & ~abort_sel_s;
         up_d   = up_q | abort_sel_s;
         dn_d   = dn_q | abort_sel_s;
         core_d = core_q | abort_sel_s;
         busy_d = 1'b0;
         done_d = 1'b0;
      end else begin
         case (state_d)
            st_assert_lp: begin
               tok_d  = tok_q & ~mask_d;
               up_d   = up_q | mask_d;
               dn_d   = dn_q | mask_d;
               core_d = core_q | mask_d;
               busy_d = 1'b1;
               done_d = 1'b0;
            end
            st_tok_hi_lp: tok_d  = tok_q | mask_d;
            st_tok_lo_lp: tok_d  = tok_q & ~mask_d;
            st_io_up_lp:  up_d   = up_q & ~mask_d;
            st_io_dn_lp:  dn_d   = dn_q & ~mask_d;
            st_done_lp: begin
               core_d = core_q & ~mask_d;
               busy_d = 1'b0;
               done_d = 1'b1;
            end
            default: begin
               tok_d = tok_q;
            end
         endcase
      end
   end

   // State and output flops; reset parks every link in reset with token low.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q <= st_idle_lp;
         cnt_q   <= cnt_zero_lp;
         w_q     <= cnt_one_lp;
         mask_q  <= links_zero_lp;
         tok_q   <= links_zero_lp;
         up_q    <= links_one_lp;
         dn_q    <= links_one_lp;
         core_q  <= links_one_lp;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         w_q     <= w_d;
         mask_q  <= mask_d;
         tok_q   <= tok_d;
         up_q    <= up_d;
         dn_q    <= dn_d;
         core_q  <= core_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign token_reset_o = tok_q;
   assign io_up_reset_o = up_q;
   assign io_dn_reset_o = dn_q;
   assign core_reset_o  = core_q;
   assign busy_o        = busy_q;
   assign done_o        = done_q;

endmodule

// File: tb/tb_bsg_chip_link_bringup_seq.sv
// Bench for bsg_chip_link_bringup_seq: directed scenarios with literal checks plus
// random start/abort traffic, all compared each cycle against a timeline model.
module tb_bsg_chip_link_bringup_seq;
   localparam int N  = 4;
   localparam int WW = 16;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic          abort;
   logic [N-1:0]  lmask;
   logic [WW-1:0] wcyc;
   logic [N-1:0]  tok, up, dn, core;
   logic          busy, done;

   int total = 0;
   int bad   = 0;
   bit chk_en = 1'b0;

   // model state: stage index derived from edges elapsed since the start edge
   logic [N-1:0] m_tok, m_up, m_dn, m_core, m_mask;
   logic         m_busy, m_done;
   int           m_k, m_w;

   initial forever #5 clk = ~clk;

   bsg_chip_link_bringup_seq #(.num_links_p(N), .wait_width_p(WW)) dut (
      .clk_i(clk), .reset_i(rst), .start_i(start), .abort_i(abort),
      .link_mask_i(lmask), .wait_cycles_i(wcyc),
      .token_reset_o(tok), .io_up_reset_o(up), .io_dn_reset_o(dn),
      .core_reset_o(core), .busy_o(busy), .done_o(done));

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic m_reset();
      m_tok = '0; m_up = '1; m_dn = '1; m_core = '1; m_mask = '0;
      m_busy = 1'b0; m_done = 1'b0; m_k = 0; m_w = 1;
   endtask

   // stage 0..5 = assert, token high, token low, io_up released, io_dn released, done
   task automatic m_stage(input int st);
      for (int i = 0; i < N; i++) begin
         if (m_mask[i]) begin
            m_tok[i]  = (st == 1);
            m_up[i]   = (st < 3);
            m_dn[i]   = (st < 4);
            m_core[i] = (st < 5);
         end
      end
      m_busy = (st < 5);
      m_done = (st == 5);
   endtask

   task automatic m_step();
      logic [N-1:0] sel;
      int st;
      if (abort) begin
         sel    = m_busy ? m_mask : lmask;
         m_up   = m_up | sel;
         m_dn   = m_dn | sel;
         m_core = m_core | sel;
         m_tok  = m_tok & ~sel;
         m_busy = 1'b0;
         m_done = 1'b0;
      end else if (m_busy) begin
         m_k++;
         st = m_k / m_w;
         if (st > 5) st = 5;
         m_stage(st);
      end else if (start) begin
         m_mask = lmask;
         m_w    = (wcyc == '0) ? 1 : int'(wcyc);
         m_k    = 0;
         m_stage(0);
      end
   endtask

   // model advances on every clock edge, resets asynchronously
   initial begin
      m_reset();
      forever begin
         @(posedge clk or posedge rst);
         if (rst) m_reset();
         else     m_step();
      end
   end

   // per-cycle comparison of all outputs against the model
   initial forever begin
      @(negedge clk);
      if (chk_en) begin
         chk("token", 32'(tok),  32'(m_tok));
         chk("io_up", 32'(up),   32'(m_up));
         chk("io_dn", 32'(dn),   32'(m_dn));
         chk("core",  32'(core), 32'(m_core));
         chk("busy",  32'(busy), 32'(m_busy));
         chk("done",  32'(done), 32'(m_done));
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   // drive a one-cycle start; returns while cycle 1 of the sequence is visible
   task automatic start_seq(input logic [N-1:0] m, input logic [WW-1:0] w);
      lmask = m; wcyc = w; start = 1'b1;
      cyc(1);
      start = 1'b0;
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; abort = 1'b0; lmask = '0; wcyc = '0;
      cyc(2);
      chk("rst_tok",  32'(tok),  32'h0);
      chk("rst_up",   32'(up),   32'hF);
      chk("rst_core", 32'(core), 32'hF);
      chk("rst_busy", 32'(busy), 32'h0);
      chk_en = 1'b1;
      rst = 1'b0;
      cyc(1);

      // scenario 1: mask 0101, W=2
      start_seq(4'b0101, 16'd2);
      chk("s1_busy_c1", 32'(busy), 32'h1);
      cyc(2); chk("s1_tok_c3", 32'(tok), 32'h5);
      cyc(2); chk("s1_tok_c5", 32'(tok), 32'h0);
      cyc(2); chk("s1_up_c7",  32'(up),  32'hA);
      cyc(2); chk("s1_dn_c9",  32'(dn),  32'hA);
      cyc(1); chk("s1_done_c10", 32'(done), 32'h0);
      cyc(1); chk("s1_done_c11", 32'(done), 32'h1);
      chk("s1_core_c11", 32'(core), 32'hA);

      // scenario 5: only link 1 sequences, links 0/2 stay live
      start_seq(4'b0010, 16'd3);
      cyc(15);
      chk("s5_done", 32'(done), 32'h1);
      chk("s5_core", 32'(core), 32'h8);

      // scenario 3: start re-pulsed mid-run is ignored
      start_seq(4'b0101, 16'd2);
      cyc(2); lmask = 4'b1111; wcyc = 16'd5; start = 1'b1;
      cyc(1); start = 1'b0;
      chk("s3_tok_c4", 32'(tok), 32'h5);
      cyc(4); start = 1'b1;
      cyc(1); start = 1'b0;
      cyc(1); chk("s3_done_c10", 32'(done), 32'h0);
      cyc(1); chk("s3_done_c11", 32'(done), 32'h1);
      chk("s3_core_c11", 32'(core), 32'h8);

      // scenario 4: abort at cycle 8
      start_seq(4'b0101, 16'd2);
      cyc(7); lmask = 4'b0000; abort = 1'b1;
      cyc(1); abort = 1'b0;
      chk("s4_up",   32'(up),   32'hD);
      chk("s4_core", 32'(core), 32'hD);
      chk("s4_tok",  32'(tok),  32'h0);
      chk("s4_busy", 32'(busy), 32'h0);

      // abort with start while idle: abort wins, selected link 1 goes to reset
      lmask = 4'b0010; abort = 1'b1; start = 1'b1;
      cyc(1); abort = 1'b0; start = 1'b0;
      chk("ab_busy", 32'(busy), 32'h0);
      chk("ab_up",   32'(up),   32'hF);

      // scenario 2: W=0 acts as W=1
      start_seq(4'b1111, 16'd0);
      cyc(4); chk("s2_done_c5", 32'(done), 32'h0);
      cyc(1); chk("s2_done_c6", 32'(done), 32'h1);
      chk("s2_core_c6", 32'(core), 32'h0);

      // scenario 6: async reset mid-cycle, then a fresh run
      start_seq(4'b1111, 16'd3);
      cyc(4);
      #2 rst = 1'b1;
      #1;
      chk("s6_tok",  32'(tok),  32'h0);
      chk("s6_up",   32'(up),   32'hF);
      chk("s6_core", 32'(core), 32'hF);
      chk("s6_busy", 32'(busy), 32'h0);
      cyc(1); rst = 1'b0;
      cyc(1);
      start_seq(4'b0110, 16'd1);
      cyc(5);
      chk("s6_done_c6", 32'(done), 32'h1);
      chk("s6_core_c6", 32'(core), 32'h9);

      // random traffic
      for (int i = 0; i < 600; i++) begin
         lmask = N'($urandom);
         wcyc  = WW'($urandom_range(0, 4));
         start = ($urandom_range(0, 7) == 0);
         abort = ($urandom_range(0, 39) == 0);
         cyc(1);
      end
      start = 1'b0; abort = 1'b0;
      cyc(2);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
